// File: rtl/ps2_key_pkg.sv
// Shared constants and types for the PS/2 key FIFO.
package ps2_key_pkg;

  localparam int DEFAULT_DEPTH = 16;

  localparam logic [7:0] LEFT_SHIFT_CODE  = 8'h12;
  localparam logic [7:0] RIGHT_SHIFT_CODE = 8'h59;

  // One stored key: shift state at capture time plus the scan code.
  typedef struct packed {
    logic       shift;
    logic [7:0] code;
  } key_entry_t;

endpackage

// File: rtl/ps2_key_storage.sv
// DEPTH x 9 register array: one synchronous write port, one async read port.
// Contents are deliberately not reset; occupancy is tracked by the parent.
module ps2_key_storage
  import ps2_key_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  key_entry_t    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output key_entry_t    o_rdata
);

  key_entry_t r_mem [DEPTH];

  // Write the entry at the write pointer when a push is accepted.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ps2_key_fifo.sv
// First-word-fall-through FIFO of PS/2 make codes.
// Optional feature: define SHIFT_TRACK_EN to absorb the left/right shift
// make codes into a shift_status bit stored with every following key.
// DEPTH must be a power of two in 2..64 so pointers wrap naturally.
module ps2_key_fifo
  import ps2_key_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     Clock_50,
  input  logic                     Resetn,
  input  logic [7:0]               PS2_code,
  input  logic                     PS2_code_ready,
  input  logic                     PS2_make_code,
  input  logic                     Clear,
  output logic [8:0]               Key_data,
  output logic                     Key_valid,
  input  logic                     Key_ready,
  output logic [$clog2(DEPTH):0]   Key_count,
  output logic                     Fifo_full,
  output logic                     Overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic          r_code_ready_d;
  logic          r_armed;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;
  logic          r_shift;
  logic [8:0]    r_last;

  logic       w_capture;
  logic       w_push_req;
  logic       w_push;
  logic       w_pop;
  logic       w_drop;
  logic       w_empty;
  logic       w_full;
  logic       w_set_shift;
  logic       w_clr_shift;
  key_entry_t w_wdata;
  key_entry_t w_rdata;

  // r_armed blocks a level that was already high across reset from being
  // mistaken for a fresh edge; it arms once the level is seen low.
  assign w_capture = PS2_code_ready & ~r_code_ready_d & r_armed & PS2_make_code;

`ifdef SHIFT_TRACK_EN
  assign w_set_shift = w_capture & (PS2_code == LEFT_SHIFT_CODE);
  assign w_clr_shift = w_capture & (PS2_code == RIGHT_SHIFT_CODE);
  assign w_push_req  = w_capture & ~w_set_shift & ~w_clr_shift;
`else
  assign w_set_shift = 1'b0;
  assign w_clr_shift = 1'b0;
  assign w_push_req  = w_capture;
`endif

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = ~w_empty & Key_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push  = w_push_req & (~w_full | w_pop);
  assign w_drop  = w_push_req & w_full & ~w_pop;

  assign w_wdata.shift = r_shift;
  assign w_wdata.code  = PS2_code;

  ps2_key_storage #(.DEPTH(DEPTH), .AW(AW)) u_storage (
    .i_clk   (Clock_50),
    .i_we    (w_push & ~Clear),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Edge-detect state: registered level plus the post-reset arming bit.
  always_ff @(posedge Clock_50) begin
    if (!Resetn) begin
      r_code_ready_d <= 1'b0;
      r_armed        <= ~PS2_code_ready;
    end else begin
      r_code_ready_d <= PS2_code_ready;
      r_armed        <= r_armed | ~PS2_code_ready;
    end
  end

  // Pointers, occupancy, sticky overflow and shift status; Clear wins.
  always_ff @(posedge Clock_50) begin
    if (!Resetn || Clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_shift    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop)      r_overflow <= 1'b1;
      if (w_set_shift) r_shift    <= 1'b1;
      if (w_clr_shift) r_shift    <= 1'b0;
    end
  end

  // Remember the last presented head so Key_data holds while empty.
  always_ff @(posedge Clock_50) begin
    if (!Resetn)        r_last <= 9'h000;
    else if (!w_empty)  r_last <= w_rdata;
  end

  assign Key_valid = ~w_empty;
  assign Key_data  = w_empty ? r_last : w_rdata;
  assign Key_count = r_count;
  assign Fifo_full = w_full;
  assign Overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed self-checking bench for ps2_key_fifo (DEPTH=16).
module tb_ps2_key_fifo;

  localparam int DEPTH = 16;

  logic       Clock_50 = 1'b0;
  logic       Resetn = 1'b0;
  logic [7:0] PS2_code = 8'h00;
  logic       PS2_code_ready = 1'b0;
  logic       PS2_make_code = 1'b0;
  logic       Clear = 1'b0;
  logic [8:0] Key_data;
  logic       Key_valid;
  logic       Key_ready = 1'b0;
  logic [4:0] Key_count;
  logic       Fifo_full;
  logic       Overflow;

  int total = 0;
  int bad   = 0;

  ps2_key_fifo #(.DEPTH(DEPTH)) dut (
    .Clock_50       (Clock_50),
    .Resetn         (Resetn),
    .PS2_code       (PS2_code),
    .PS2_code_ready (PS2_code_ready),
    .PS2_make_code  (PS2_make_code),
    .Clear          (Clear),
    .Key_data       (Key_data),
    .Key_valid      (Key_valid),
    .Key_ready      (Key_ready),
    .Key_count      (Key_count),
    .Fifo_full      (Fifo_full),
    .Overflow       (Overflow)
  );

  always #10 Clock_50 = ~Clock_50;

  task automatic tick();
    @(posedge Clock_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One ready pulse (high one cycle, low one cycle).
  task automatic send_key(input logic [7:0] code, input logic make);
    PS2_code       = code;
    PS2_make_code  = make;
    PS2_code_ready = 1'b1;
    tick();
    PS2_code_ready = 1'b0;
    tick();
  endtask

  task automatic pop();
    Key_ready = 1'b1;
    tick();
    Key_ready = 1'b0;
  endtask

  task automatic clear_fifo();
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
  endtask

  initial begin
    logic [7:0] e;

    // Reset state
    repeat (3) tick();
    chk("rst_valid", Key_valid, 0);
    chk("rst_count", Key_count, 0);
    chk("rst_full",  Fifo_full, 0);
    chk("rst_ovf",   Overflow,  0);
    chk("rst_data",  Key_data,  9'h000);
    Resetn = 1'b1;
    tick();

    // Single make, push latency 1
    PS2_code = 8'h1C; PS2_make_code = 1'b1; PS2_code_ready = 1'b1;
    tick();
    chk("first_valid", Key_valid, 1);
    chk("first_data",  Key_data,  9'h01C);
    chk("first_count", Key_count, 1);
    PS2_code_ready = 1'b0;
    tick();
    pop();
    chk("pop_empty_valid", Key_valid, 0);
    chk("hold_data",       Key_data,  9'h01C);

    // Pop request while empty coincident with push: push wins
    PS2_code = 8'h2A; PS2_code_ready = 1'b1; Key_ready = 1'b1;
    tick();
    chk("empty_pushpop_count", Key_count, 1);
    chk("empty_pushpop_data",  Key_data,  9'h02A);
    PS2_code_ready = 1'b0; Key_ready = 1'b0;
    tick();
    pop();
    chk("drain_count", Key_count, 0);

`ifdef SHIFT_TRACK_EN
    send_key(8'h12, 1'b1);
    send_key(8'h1C, 1'b1);
    send_key(8'h59, 1'b1);
    send_key(8'h1C, 1'b1);
    chk("shift_count", Key_count, 2);
    chk("shift_data0", Key_data,  9'h11C);
    pop();
    chk("shift_data1", Key_data,  9'h01C);
    pop();
`else
    send_key(8'h12, 1'b1);
    send_key(8'h59, 1'b1);
    chk("noshift_count", Key_count, 2);
    chk("noshift_data0", Key_data,  9'h012);
    pop();
    chk("noshift_data1", Key_data,  9'h059);
    pop();
`endif
    chk("shift_drain", Key_count, 0);

    // Break codes ignored; long-held ready gives one entry
    send_key(8'hF0, 1'b0);
    send_key(8'h1C, 1'b0);
    chk("break_count", Key_count, 0);
    PS2_code = 8'h1C; PS2_make_code = 1'b1; PS2_code_ready = 1'b1;
    repeat (10) tick();
    PS2_code_ready = 1'b0;
    tick();
    chk("held_count", Key_count, 1);
    chk("held_data",  Key_data,  9'h01C);
    pop();

    // 17 makes into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_key(8'h20 + 8'(i), 1'b1);
    chk("ovf_full",  Fifo_full, 1);
    chk("ovf_count", Key_count, 16);
    chk("ovf_flag",  Overflow,  1);
    for (int i = 0; i < 16; i++) begin
      e = 8'h20 + 8'(i);
      chk($sformatf("ovf_pop%0d", i), Key_data, {1'b0, e});
      pop();
    end
    chk("ovf_drain_valid", Key_valid, 0);
    chk("ovf_sticky",      Overflow,  1);
    clear_fifo();
    chk("clr_ovf", Overflow, 0);

    // Full FIFO, simultaneous push and pop across pointer wrap
    for (int i = 0; i < 16; i++) send_key(8'h40 + 8'(i), 1'b1);
    chk("wrap_full", Fifo_full, 1);
    for (int j = 0; j < 2; j++) begin
      PS2_code = 8'h60 + 8'(j); PS2_code_ready = 1'b1; Key_ready = 1'b1;
      tick();
      e = 8'h41 + 8'(j);
      chk($sformatf("wrap_pp_count%0d", j), Key_count, 16);
      chk($sformatf("wrap_pp_head%0d", j),  Key_data,  {1'b0, e});
      PS2_code_ready = 1'b0; Key_ready = 1'b0;
      tick();
    end
    chk("wrap_ovf", Overflow, 0);
    for (int i = 0; i < 16; i++) begin
      e = (i < 14) ? 8'h42 + 8'(i) : 8'h60 + 8'(i - 14);
      chk($sformatf("wrap_pop%0d", i), Key_data, {1'b0, e});
      pop();
    end
    chk("wrap_drain", Key_count, 0);

    // Clear coincident with a capture edge
    send_key(8'h31, 1'b1);
    send_key(8'h32, 1'b1);
    send_key(8'h33, 1'b1);
    chk("pre_clr_count", Key_count, 3);
    PS2_code = 8'h34; PS2_code_ready = 1'b1; Clear = 1'b1;
    tick();
    Clear = 1'b0;
    chk("clr_count", Key_count, 0);
    chk("clr_valid", Key_valid, 0);
    chk("clr_ovf2",  Overflow,  0);
    tick();
    PS2_code_ready = 1'b0;
    tick();
    chk("clr_no_late_push", Key_count, 0);

    // Reset mid-stream with ready held high across it
    send_key(8'h35, 1'b1);
    send_key(8'h36, 1'b1);
    PS2_code = 8'h37; PS2_code_ready = 1'b1; Resetn = 1'b0;
    repeat (2) tick();
    chk("mid_rst_count", Key_count, 0);
    chk("mid_rst_data",  Key_data,  9'h000);
    Resetn = 1'b1;
    repeat (2) tick();
    chk("post_rst_no_capture", Key_count, 0);
    PS2_code_ready = 1'b0;
    tick();
    send_key(8'h38, 1'b1);
    chk("post_rst_count", Key_count, 1);
    chk("post_rst_data",  Key_data,  9'h038);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_key_fifo.md
PS2_KEY_FIFO -- requirements
Module: ps2_key_fifo

Interface
REQ-001 Parameter DEPTH, default 16, meaning FIFO entries; SHALL be a power of two, 2..64.
REQ-002 Port Clock_50  input  1  meaning single 50 MHz clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port Resetn  input  1  meaning synchronous, active-low reset, sampled only on the rising edge of Clock_50.
REQ-004 Port PS2_code  input  8  meaning scan code from the PS2 controller.
REQ-005 Port PS2_code_ready  input  1  meaning level from the PS2 controller; a new code is present on its 0->1 edge.
REQ-006 Port PS2_make_code  input  1  meaning 1 = make code, 0 = break code.
REQ-007 Port Clear  input  1  meaning synchronous flush.
REQ-008 Port Key_data  output  9  meaning head entry {shift, code[7:0]}.
REQ-009 Port Key_valid  output  1  meaning head entry is valid.
REQ-010 Port Key_ready  input  1  meaning consumer accepts the head entry.
REQ-011 Port Key_count  output  log2(DEPTH)+1  meaning current occupancy.
REQ-012 Port Fifo_full  output  1  meaning Key_count == DEPTH.
REQ-013 Port Overflow  output  1  meaning sticky flag: a key was dropped.

Function
REQ-014 Edge detect: PS2_code_ready SHALL be registered once; a capture event occurs on a cycle where PS2_code_ready=1, the registered copy=0, and PS2_make_code=1.
REQ-015 Break codes and repeated-high levels SHALL never generate a capture event.
REQ-016 Each capture event SHALL push {shift_status, PS2_code} at the write pointer; Key_valid SHALL rise on the next cycle (push latency 1, first-word-fall-through).
REQ-017 Pop: when Key_valid=1 and Key_ready=1 on a clock edge, the head SHALL be removed; the next entry SHALL appear on Key_data in the following cycle.
REQ-018 Key_ready with Key_valid=0 SHALL have no effect.
REQ-019 Pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH with no gap.
REQ-020 Simultaneous push and pop SHALL both succeed and leave Key_count unchanged, including when full.
REQ-021 Simultaneous push and pop when empty: the push SHALL succeed and the pop SHALL be ignored (count becomes 1).
REQ-022 A push while full without a pop SHALL be dropped; Overflow SHALL set and hold until Clear or reset.
REQ-023 Clear SHALL take priority over push and pop: Key_count=0, both pointers=0, Overflow=0, shift_status=0 on the next cycle; a capture in the same cycle SHALL be discarded.
REQ-024 Key_data SHALL hold its last value when Key_valid=0; the consumer SHALL ignore it.
REQ-025 No explicit FSM: behaviour SHALL be fully defined by pointers, count, shift_status and the edge register.

Reset
REQ-026 Resetn=0 SHALL force Key_valid=0, Key_count=0, Fifo_full=0, Overflow=0, Key_data=9'h000, pointers=0, shift_status=0, and the edge register=0.
REQ-027 Reset asserted mid-stream SHALL discard all stored keys; a PS2_code_ready level still high after reset SHALL not produce a capture.
REQ-028 Storage array contents need not be reset.

Configuration
REQ-029 Macro SHIFT_TRACK_EN.
- Defined: make code 8'h12 SHALL set shift_status, 8'h59 SHALL clear it, and neither SHALL be pushed.
- Undefined: 8'h12 and 8'h59 SHALL be pushed as ordinary keys, and bit 8 of every entry SHALL be 0.

Structure
REQ-030 Package ps2_key_pkg SHALL hold:
- constants LEFT_SHIFT_CODE=8'h12 and RIGHT_SHIFT_CODE=8'h59;
- typedef key_entry_t (packed: shift, code[7:0]);
- the default DEPTH.
REQ-031 Sub-module ps2_key_storage (DEPTH x 9 register array, one write port, one async read port) SHALL hold the entries; all control logic SHALL stay in ps2_key_fifo.

Verification
REQ-032 Reset, then one make 8'h1C (Key_ready=0) -> Key_valid=1 one cycle after the edge, Key_data=9'h01C, Key_count=1.
REQ-033 SHIFT_TRACK_EN defined, make 8'h12, then 8'h1C, then 8'h59, then 8'h1C -> exactly 2 entries: 9'h11C then 9'h01C.
REQ-034 17 makes with DEPTH=16 and no pops -> Fifo_full=1, Key_count=16, Overflow=1; pops return the first 16 codes in order.
REQ-035 Full FIFO, push and pop in the same cycle -> Key_count stays 16, Overflow stays 0, and the order is preserved across pointer wrap.
REQ-036 Break 8'hF0 / 8'h1C sequence, and PS2_code_ready held high 10 cycles -> exactly one entry (from the make only).
REQ-037 Three entries stored, Clear pulsed coincident with a capture edge -> next cycle Key_count=0, Key_valid=0, Overflow=0; no entry from the coincident key.
